cpu2_reset_seq: RTL and testbench
=================================

# cpu2_reset_seq

Power-up and reset sequencer for the second Cortex-M0 core, sitting directly downstream of the AHB control slave that drives `cpu2_en`. It converts the `cpu2_en` level into an ordered clock-enable / reset-release sequence for core 2. It also handles core-2 soft resets (`SYSRESETREQ`, optional `LOCKUP`) and exposes sequencer state and a soft-reset event counter for readback.

## Interface
- `RST_HOLD`, default 16: cycles `cpu2_hresetn` is held low with clock running, legal range 1..255.
- `LOCKUP_RST`, default 1: when set, `cpu2_lockup` triggers a soft reset; when 0 it is ignored.
- `CNT_W`, default 8: width of the soft-reset event counter.

Ports:
- `HCLK` in 1: system clock; all logic on its rising edge.
- `HRESETn` in 1: reset, asynchronous, active-low.
- `cpu2_en` in 1: run request, synchronous to `HCLK`.
- `cpu2_sysresetreq` in 1: core-2 `SYSRESETREQ` level.
- `cpu2_lockup` in 1: core-2 `LOCKUP` level.
- `rst_cnt_clr` in 1: one-cycle pulse that clears the event counter.
- `cpu2_clk_en` out 1: clock-gate enable for core 2.
- `cpu2_hresetn` out 1: active-low reset to core 2.
- `cpu2_state` out 3: current sequencer state encoding.
- `cpu2_rst_cnt` out CNT_W: saturating count of soft resets.

## Operation
- Single Moore FSM, state register plus hold counter `cnt` (8 bit). All outputs are registered and decoded from the next state, so they change on the same edge as the state.
- State encoding: OFF=0, CLK_ON=1, RUN=2, SOFT=3, STOP=4. Values 5–7 are unreachable and recover to OFF on the next edge.

Output decode:
- OFF: `clk_en`=0, `hresetn`=0.
- CLK_ON, SOFT and STOP: `clk_en`=1, `hresetn`=0.
- RUN: `clk_en`=1, `hresetn`=1.

Transitions:
- **OFF:** `cpu2_en`=1 → CLK_ON, load `cnt`=RST_HOLD-1.
- **CLK_ON:**
  - `cpu2_en`=0 → OFF (reset never released).
  - else `cnt`≠0 → decrement.
  - else → RUN.
- **RUN**, in priority order:
  - `cpu2_en`=0 → STOP, load `cnt`.
  - else `cpu2_sysresetreq`=1, or (`cpu2_lockup`=1 and LOCKUP_RST) → SOFT, load `cnt`, increment event counter.
- **SOFT:**
  - `cnt`≠0 → decrement, regardless of `cpu2_en`.
  - `cnt`=0 → RUN if `cpu2_en`=1, else OFF.
- **STOP:**
  - `cnt`≠0 → decrement; `cpu2_en` is ignored.
  - `cnt`=0 → OFF. OFF re-evaluates `cpu2_en` on the following edge.

Event counter:
- Saturates at all-ones.
- `rst_cnt_clr` alone → 0.
- `rst_cnt_clr` together with an increment → 1.

## Timing
- Reset values:
  - state OFF, `cnt`=0.
  - `cpu2_clk_en`=0, `cpu2_hresetn`=0.
  - `cpu2_state`=0, `cpu2_rst_cnt`=0.
- Power-up latency:
  - `cpu2_en` first seen high at edge k → `clk_en` rises after edge k.
  - `hresetn` rises after edge k+RST_HOLD.
  - Core 2 therefore sees exactly RST_HOLD clocked cycles in reset.
- Power-down:
  - `cpu2_en` seen low at edge k → `hresetn` falls after edge k.
  - `clk_en` falls after edge k+RST_HOLD.
- Soft reset:
  - Request seen at edge k → `hresetn` low after edge k.
  - `hresetn` high again after edge k+RST_HOLD if `cpu2_en` is still 1.
- Simultaneous `cpu2_en` fall and soft-reset request in RUN: STOP wins, counter not incremented.
- Request inputs stay high while in SOFT: no re-trigger and no additional count. The next RUN cycle re-samples them.
- `HRESETn` asserted mid-sequence: immediate return to reset values; `hresetn` goes low asynchronously.
- RST_HOLD=1: CLK_ON, SOFT and STOP each last exactly one cycle.

## Structure
- Shared include `cpu2_defs.vh` holds:
  - state encodings `CPU2_OFF` through `CPU2_STOP`;
  - default `RST_HOLD`;
  - readback address `32'h5000_0008`, used later by the control slave to map `cpu2_state` and `cpu2_rst_cnt`.
- One sub-module, `cpu2_hold_cnt`: loadable 8-bit down-counter with `load`, `dec` and `zero` outputs. The FSM stays in the top module.

## Test plan
- **Power-up:** reset release, then `cpu2_en`=1 with RST_HOLD=16 → `clk_en`=1 one cycle later; `hresetn`=1 exactly 16 edges after; `cpu2_state` sequence 0→1→2.
- **Abort during CLK_ON:** `cpu2_en` pulsed high for 5 cycles → returns to OFF; `hresetn` never rises; `clk_en` drops.
- **Soft reset:** `cpu2_sysresetreq` high for 3 cycles in RUN → `hresetn` low for 16 cycles, then high; `cpu2_rst_cnt`=1.
- **Lockup gating:** `cpu2_lockup`=1 in RUN with LOCKUP_RST=0 → state stays RUN, count unchanged. With LOCKUP_RST=1 → SOFT entered.
- **Power-down precedence:** `cpu2_en`=0 and `cpu2_sysresetreq`=1 on the same edge in RUN → STOP, count unchanged; `clk_en` low 16 edges later. `cpu2_en` re-raised during STOP → OFF, then CLK_ON.
- **Counter edges:** 255 soft resets → count holds 255. `rst_cnt_clr` coincident with a soft reset → count=1. Async `HRESETn` during SOFT → all outputs at reset values immediately.

Source files
------------

// File: rtl/cpu2_reset_seq_pkg.sv
// Shared definitions for the core-2 power-up/reset sequencer: state codes, hold default,
// readback address used by the AHB control slave, and the state-to-output decode.
package cpu2_reset_seq_pkg;

    typedef enum logic [2:0] {
        CPU2_OFF    = 3'd0,
        CPU2_CLK_ON = 3'd1,
        CPU2_RUN    = 3'd2,
        CPU2_SOFT   = 3'd3,
        CPU2_STOP   = 3'd4
    } cpu2_state_e;

    localparam int unsigned CPU2_RST_HOLD_DEF = 16;

    // Control slave maps {cpu2_rst_cnt, cpu2_state} here for software readback.
    localparam logic [31:0] CPU2_STAT_ADDR = 32'h5000_0008;

    typedef struct packed {
        logic clk_en;
        logic hresetn;
    } cpu2_ctl_t;

    function automatic cpu2_ctl_t cpu2_decode(input cpu2_state_e s);
        cpu2_ctl_t c;
        c.clk_en  = 1'b1;
        c.hresetn = 1'b0;
        case (s)
            CPU2_OFF: c.clk_en  = 1'b0;
            CPU2_RUN: c.hresetn = 1'b1;
            default:  c.hresetn = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cpu2_reset_seq_hold_cnt.sv
// Loadable 8-bit hold down-counter; load wins over dec, dec stops at zero.
// zero_o reflects the registered count, so it is valid one cycle after a load.
module cpu2_hold_cnt
    import cpu2_reset_seq_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic       dec_i,
    output logic       zero_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == 8'd0);

endmodule

// File: rtl/cpu2_reset_seq.sv
// Turns the cpu2_en level into an ordered clock-enable / reset-release sequence for core 2,
// handles core-2 soft resets and counts them. Outputs are registered from the next state.
module cpu2_reset_seq
    import cpu2_reset_seq_pkg::*;
#(
    parameter int unsigned RST_HOLD   = CPU2_RST_HOLD_DEF,
    parameter bit          LOCKUP_RST = 1'b1,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             cpu2_en,
    input  logic             cpu2_sysresetreq,
    input  logic             cpu2_lockup,
    input  logic             rst_cnt_clr,
    output logic             cpu2_clk_en,
    output logic             cpu2_hresetn,
    output logic [2:0]       cpu2_state,
    output logic [CNT_W-1:0] cpu2_rst_cnt
);

    // The counter is loaded with HOLD-1 so the final zero cycle completes the hold.
    localparam logic [7:0]       HOLD_LD = 8'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    cpu2_state_e      state_q;
    cpu2_state_e      state_d;
    cpu2_ctl_t        ctl_q;
    cpu2_ctl_t        ctl_d;
    logic [CNT_W-1:0] rst_cnt_q;
    logic [CNT_W-1:0] rst_cnt_d;

    logic hold_load;
    logic hold_dec;
    logic hold_zero;
    logic evt_inc;
    logic soft_req;

    assign soft_req = cpu2_sysresetreq | (cpu2_lockup & LOCKUP_RST);

    cpu2_hold_cnt u_hold (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .load_i     (hold_load),
        .load_val_i (HOLD_LD),
        .dec_i      (hold_dec),
        .zero_o     (hold_zero)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= CPU2_OFF;
            ctl_q   <= '0;
        end else begin
            state_q <= state_d;
            ctl_q   <= ctl_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_load = 1'b0;
        hold_dec  = 1'b0;
        evt_inc   = 1'b0;
        case (state_q)
            CPU2_OFF: begin
                if (cpu2_en) begin
                    state_d   = CPU2_CLK_ON;
                    hold_load = 1'b1;
                end
            end
            CPU2_CLK_ON: begin
                if (!cpu2_en) begin
                    state_d = CPU2_OFF;
                end else if (!hold_zero) begin
                    hold_dec = 1'b1;
                end else begin
                    state_d = CPU2_RUN;
                end
            end
            CPU2_RUN: begin
                // Power-down outranks a coincident soft-reset request.
                if (!cpu2_en) begin
                    state_d   = CPU2_STOP;
                    hold_load = 1'b1;
                end else if (soft_req) begin
                    state_d   = CPU2_SOFT;
                    hold_load = 1'b1;
                    evt_inc   = 1'b1;
                end
            end
            CPU2_SOFT: begin
                if (!hold_zero) begin
                    hold_dec = 1'b1;
                end else begin
                    state_d = cpu2_en ? CPU2_RUN : CPU2_OFF;
                end
            end
            CPU2_STOP: begin
                if (!hold_zero) begin
                    hold_dec = 1'b1;
                end else begin
                    state_d = CPU2_OFF;
                end
            end
            default: state_d = CPU2_OFF;
        endcase
    end

    always_comb begin
        ctl_d = cpu2_decode(state_d);
    end

    always_comb begin
        rst_cnt_d = rst_cnt_q;
        if (rst_cnt_clr) begin
            rst_cnt_d = evt_inc ? CNT_ONE : '0;
        end else if (evt_inc && (rst_cnt_q != CNT_MAX)) begin
            rst_cnt_d = rst_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rst_cnt_q <= '0;
        end else begin
            rst_cnt_q <= rst_cnt_d;
        end
    end

    assign cpu2_clk_en  = ctl_q.clk_en;
    assign cpu2_hresetn = ctl_q.hresetn;
    assign cpu2_state   = state_q;
    assign cpu2_rst_cnt = rst_cnt_q;

endmodule

// File: tb/tb_cpu2_reset_seq.sv
// Directed bench for cpu2_reset_seq: three instances (default, lockup ignored, one-cycle hold)
// share stimulus; a phase/time-left model is compared every cycle, plus literal spot checks.
module tb_cpu2_reset_seq;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    logic en = 1'b0;
    logic sreq = 1'b0;
    logic lock = 1'b0;
    logic clr = 1'b0;

    logic       clk_en [3];
    logic       rstn   [3];
    logic [2:0] st     [3];
    logic [7:0] rcnt   [3];

    int checks = 0;
    int failures = 0;

    always #5 HCLK = ~HCLK;

    cpu2_reset_seq u0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .cpu2_en(en), .cpu2_sysresetreq(sreq),
        .cpu2_lockup(lock), .rst_cnt_clr(clr), .cpu2_clk_en(clk_en[0]),
        .cpu2_hresetn(rstn[0]), .cpu2_state(st[0]), .cpu2_rst_cnt(rcnt[0])
    );

    cpu2_reset_seq #(.LOCKUP_RST(1'b0)) u1 (
        .HCLK(HCLK), .HRESETn(HRESETn), .cpu2_en(en), .cpu2_sysresetreq(sreq),
        .cpu2_lockup(lock), .rst_cnt_clr(clr), .cpu2_clk_en(clk_en[1]),
        .cpu2_hresetn(rstn[1]), .cpu2_state(st[1]), .cpu2_rst_cnt(rcnt[1])
    );

    cpu2_reset_seq #(.RST_HOLD(1)) u2 (
        .HCLK(HCLK), .HRESETn(HRESETn), .cpu2_en(en), .cpu2_sysresetreq(sreq),
        .cpu2_lockup(lock), .rst_cnt_clr(clr), .cpu2_clk_en(clk_en[2]),
        .cpu2_hresetn(rstn[2]), .cpu2_state(st[2]), .cpu2_rst_cnt(rcnt[2])
    );

    // Model phases; the numeric values are the externally visible state codes.
    localparam int P_IDLE = 0, P_WARM = 1, P_RUN = 2, P_SOFT = 3, P_STOP = 4;
    int hold_of [3] = '{16, 16, 1};
    bit lk_of   [3] = '{1'b1, 1'b0, 1'b1};
    int m_phase [3] = '{0, 0, 0};
    int m_left  [3] = '{0, 0, 0};   // edges still to spend in the current hold phase
    int m_cnt   [3] = '{0, 0, 0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step(input int i);
        int nph;
        int nleft;
        bit inc;
        nph = m_phase[i];
        nleft = m_left[i];
        inc = 1'b0;
        case (m_phase[i])
            P_IDLE: if (en) begin nph = P_WARM; nleft = hold_of[i]; end
            P_WARM: begin
                if (!en) nph = P_IDLE;
                else begin
                    nleft = nleft - 1;
                    if (nleft == 0) nph = P_RUN;
                end
            end
            P_RUN: begin
                if (!en) begin nph = P_STOP; nleft = hold_of[i]; end
                else if (sreq || (lock && lk_of[i])) begin
                    nph = P_SOFT; nleft = hold_of[i]; inc = 1'b1;
                end
            end
            P_SOFT: begin
                nleft = nleft - 1;
                if (nleft == 0) nph = en ? P_RUN : P_IDLE;
            end
            default: begin
                nleft = nleft - 1;
                if (nleft == 0) nph = P_IDLE;
            end
        endcase
        if (clr) m_cnt[i] = inc ? 1 : 0;
        else if (inc && m_cnt[i] < 255) m_cnt[i] = m_cnt[i] + 1;
        m_phase[i] = nph;
        m_left[i] = nleft;
    endtask

    // Model advances on each rising edge; outputs are compared on the falling edge.
    initial begin
        forever begin
            @(posedge HCLK);
            if (HRESETn) begin
                for (int i = 0; i < 3; i++) model_step(i);
            end
            @(negedge HCLK);
            if (!HRESETn) begin
                for (int i = 0; i < 3; i++) begin
                    m_phase[i] = P_IDLE; m_left[i] = 0; m_cnt[i] = 0;
                end
            end
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("model u%0d clk_en", i), clk_en[i], (m_phase[i] != P_IDLE));
                chk($sformatf("model u%0d hresetn", i), rstn[i], (m_phase[i] == P_RUN));
                chk($sformatf("model u%0d state", i), st[i], m_phase[i]);
                chk($sformatf("model u%0d rst_cnt", i), rcnt[i], m_cnt[i]);
            end
        end
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        int n;
        bit seen;

        // Reset values
        repeat (3) tick();
        chk("rst clk_en", clk_en[0], 0);
        chk("rst hresetn", rstn[0], 0);
        chk("rst state", st[0], 0);
        chk("rst rst_cnt", rcnt[0], 0);
        HRESETn = 1'b1;
        repeat (2) tick();
        chk("idle state", st[0], 0);

        // Power-up: clk_en one edge after en, hresetn 16 edges after
        en = 1'b1;
        tick();
        chk("pu clk_en", clk_en[0], 1);
        chk("pu hresetn held", rstn[0], 0);
        chk("pu state clk_on", st[0], 1);
        chk("pu hold1 state", st[2], 1);
        n = 0;
        while (rstn[0] !== 1'b1 && n < 40) begin
            tick();
            n++;
            if (n == 1) chk("pu hold1 hresetn", rstn[2], 1);
        end
        chk("pu hold edges", n, 16);
        chk("pu state run", st[0], 2);

        // Soft reset: request held 3 cycles, counted once
        sreq = 1'b1;
        tick();
        chk("soft hresetn low", rstn[0], 0);
        chk("soft state", st[0], 3);
        chk("soft cnt", rcnt[0], 1);
        n = 0;
        while (rstn[0] !== 1'b1 && n < 40) begin
            tick();
            n++;
            if (n == 2) sreq = 1'b0;
        end
        chk("soft hold edges", n, 16);
        chk("soft no retrigger", rcnt[0], 1);

        // Lockup gating
        lock = 1'b1;
        tick();
        lock = 1'b0;
        chk("lockup ignored state", st[1], 2);
        chk("lockup ignored cnt", rcnt[1], 1);
        chk("lockup soft state", st[0], 3);
        chk("lockup soft cnt", rcnt[0], 2);
        repeat (20) tick();
        chk("lockup back run", st[0], 2);

        // Power-down beats coincident soft reset; en re-raised in STOP is ignored
        en = 1'b0;
        sreq = 1'b1;
        tick();
        sreq = 1'b0;
        chk("pd state stop", st[0], 4);
        chk("pd cnt unchanged", rcnt[0], 2);
        chk("pd hresetn low", rstn[0], 0);
        chk("pd clk_en kept", clk_en[0], 1);
        n = 0;
        while (clk_en[0] !== 1'b0 && n < 40) begin
            tick();
            n++;
            if (n == 4) en = 1'b1;
        end
        chk("pd hold edges", n, 16);
        chk("pd state off", st[0], 0);
        tick();
        chk("pd re-enable clk_on", st[0], 1);
        repeat (20) tick();

        // Abort during CLK_ON
        en = 1'b0;
        repeat (20) tick();
        chk("abort pre off", st[0], 0);
        en = 1'b1;
        seen = 1'b0;
        for (int j = 0; j < 5; j++) begin
            tick();
            if (rstn[0] === 1'b1) seen = 1'b1;
        end
        chk("abort mid state", st[0], 1);
        en = 1'b0;
        tick();
        chk("abort state off", st[0], 0);
        chk("abort clk_en low", clk_en[0], 0);
        repeat (20) begin
            tick();
            if (rstn[0] === 1'b1) seen = 1'b1;
        end
        chk("abort hresetn never", seen, 0);

        // Counter clear and saturation
        en = 1'b1;
        repeat (20) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr alone", rcnt[0], 0);
        for (int j = 1; j <= 256; j++) begin
            sreq = 1'b1;
            tick();
            sreq = 1'b0;
            repeat (16) tick();
            if (j == 255) chk("sat reach", rcnt[0], 255);
        end
        chk("sat hold", rcnt[0], 255);
        chk("sat state run", st[0], 2);

        // Clear coincident with a soft reset
        sreq = 1'b1;
        clr = 1'b1;
        tick();
        sreq = 1'b0;
        clr = 1'b0;
        chk("clr+inc cnt", rcnt[0], 1);
        chk("clr+inc state", st[0], 3);

        // Asynchronous reset in SOFT
        repeat (3) tick();
        #1;
        HRESETn = 1'b0;
        #1;
        chk("arst clk_en", clk_en[0], 0);
        chk("arst hresetn", rstn[0], 0);
        chk("arst state", st[0], 0);
        chk("arst rst_cnt", rcnt[0], 0);
        repeat (2) tick();
        HRESETn = 1'b1;
        repeat (20) tick();
        chk("post arst run", st[0], 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
